// File: rtl/dffram_bist_pkg.sv
// Shared types and march table for the DFFRAM256x16 March C- BIST controller.
// Table bit i describes march element Ei; bits 6..7 are padding so E5+1 reads as "up".
package dffram_bist_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_E0    = 4'd1,
        S_E1    = 4'd2,
        S_E2    = 4'd3,
        S_E3    = 4'd4,
        S_E4    = 4'd5,
        S_E5    = 4'd6,
        S_FLUSH = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    localparam int NUM_ELEM = 6;

    localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
    localparam logic [7:0] ELEM_RD     = 8'b0011_1110;
    localparam logic [7:0] ELEM_WR     = 8'b0001_1111;
    localparam logic [7:0] ELEM_RD_POL = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_POL = 8'b0000_1010;

    localparam int OP_CYCLES  = 256 + 4 * 512 + 256;
    localparam int DONE_CYCLE = OP_CYCLES + 2;
    localparam int NUM_READS  = 5 * 256;
    localparam int NUM_WRITES = 5 * 256;

endpackage

// File: rtl/dffram_bist_if.sv
// DFFRAM macro port as seen by the BIST (master) and the RAM (slave).
interface dffram_bist_if #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int WSIZE = 2
);
    logic [WSIZE-1:0] WE0;
    logic             EN0;
    logic [AW-1:0]    A0;
    logic [DW-1:0]    Di0;
    logic [DW-1:0]    Do0;

    modport master (output WE0, output EN0, output A0, output Di0, input Do0);
    modport slave  (input WE0, input EN0, input A0, input Di0, output Do0);
endinterface

// File: rtl/dffram_bist_addr_gen.sv
// Up/down march address counter with parallel load and terminal-address flag.
module dffram_bist_addr_gen #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          step,
    input  logic          down,
    output logic [AW-1:0] addr,
    output logic          last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (step) begin
            addr <= down ? addr - AW'(1) : addr + AW'(1);
        end
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/dffram_bist.sv
// March C- BIST controller for one DFFRAM256x16: drives the macro port, compares
// read data one cycle later and records pass/fail plus the first failing location.
module dffram_bist
    import dffram_bist_pkg::*;
#(
    parameter int              AW    = 8,
    parameter int              DW    = 16,
    parameter int              WSIZE = 2,
    parameter logic [DW-1:0]   BG    = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [AW-1:0]     fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DW-1:0]     fail_bits,
    output logic [7:0]        fail_count,
    dffram_bist_if.master     ram
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [DW-1:0] bg_word(input logic pol);
        return pol ? ~BG : BG;
    endfunction

    state_t        state, state_nxt;
    logic          phase, phase_nxt;
    logic [2:0]    elem;
    logic          is_elem, elem_rw;
    logic          ld, step, rd, wr, start_acc, at_last;
    logic [AW-1:0] ld_val, addr;

    logic          cmp_vld_p1;
    logic [DW-1:0] cmp_exp_p1;
    logic [AW-1:0] cmp_addr_p1;
    logic [2:0]    cmp_elem_p1;
    logic [DW-1:0] diff;

    assign elem    = state[2:0] - 3'd1;
    assign is_elem = (state >= S_E0) && (state <= S_E5);
    assign elem_rw = ELEM_RD[elem] & ELEM_WR[elem];

    dffram_bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clk      (CLK),
        .rst      (RST),
        .load     (ld),
        .load_val (ld_val),
        .step     (step),
        .down     (is_elem & ELEM_DOWN[elem]),
        .addr     (addr),
        .last     (at_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // Read/write pairs advance the address only after the write half.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        ld        = 1'b0;
        ld_val    = '0;
        step      = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        start_acc = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = S_E0;
                    phase_nxt = 1'b0;
                    ld        = 1'b1;
                end
            end
            S_FLUSH: state_nxt = S_DONE;
            default: begin
                if (elem_rw) begin
                    rd        = ~phase;
                    wr        = phase;
                    phase_nxt = ~phase;
                end else begin
                    rd = ELEM_RD[elem];
                    wr = ELEM_WR[elem];
                end
                if (!elem_rw || phase) begin
                    if (at_last) begin
                        state_nxt = state_t'(state + 4'd1);
                        ld        = 1'b1;
                        ld_val    = {AW{ELEM_DOWN[elem + 3'd1]}};
                    end else begin
                        step = 1'b1;
                    end
                end
            end
        endcase
    end

    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);
    assign ram.EN0 = rd | wr;
    assign ram.WE0 = {WSIZE{wr}};
    assign ram.A0  = addr;
    assign ram.Di0 = wr ? bg_word(ELEM_WR_POL[elem]) : '0;

    // p1: expected word for the read issued this cycle, checked against Do0 next cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cmp_vld_p1 <= 1'b0;
        else     cmp_vld_p1 <= rd;
    end

    always_ff @(posedge CLK) begin
        if (rd) begin
            cmp_exp_p1  <= bg_word(ELEM_RD_POL[elem]);
            cmp_addr_p1 <= addr;
            cmp_elem_p1 <= elem;
        end
    end

    assign diff = ram.Do0 ^ cmp_exp_p1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_bits  <= '0;
            fail_count <= '0;
        end else if (start_acc) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_bits  <= '0;
            fail_count <= '0;
        end else if (cmp_vld_p1 && (diff != '0)) begin
            fail       <= 1'b1;
            fail_count <= sat_inc(fail_count);
            if (!fail) begin
                fail_addr <= cmp_addr_p1;
                fail_elem <= cmp_elem_p1;
                fail_bits <= diff;
            end
        end
    end

endmodule
